// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline stall/flush/hold controller.
package pipeline_ctrl_pkg;

  localparam int unsigned RV_REG_W = 5;
  localparam logic [RV_REG_W-1:0] REG_X0 = 5'd0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_hold;
  } ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-side hazard/cache inputs and controller enables, grouped as one bundle.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import pipeline_ctrl_pkg::*;

  logic [RV_REG_W-1:0] id_rs1_i;
  logic [RV_REG_W-1:0] id_rs2_i;
  logic                id_use_rs1_i;
  logic                id_use_rs2_i;
  logic                id_branch_i;
  logic                id_branch_taken_i;
  logic [RV_REG_W-1:0] ex_rd_i;
  logic                ex_reg_write_i;
  logic                ex_mem_read_i;
  logic [RV_REG_W-1:0] mem_rd_i;
  logic                mem_mem_read_i;
  logic                dmem_req_i;
  logic                dmem_ready_i;

  logic                pc_write_o;
  logic                ifid_write_o;
  logic                ifid_flush_o;
  logic                idex_bubble_o;
  logic                pipe_hold_o;
  logic                err_timeout_o;
  logic [CNT_W-1:0]    stall_cnt_o;
  logic [CNT_W-1:0]    flush_cnt_o;
  logic [CNT_W-1:0]    wait_cnt_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, id_branch_i, id_branch_taken_i,
           ex_rd_i, ex_reg_write_i, ex_mem_read_i, mem_rd_i, mem_mem_read_i,
           dmem_req_i, dmem_ready_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
           err_timeout_o, stall_cnt_o, flush_cnt_o, wait_cnt_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, id_branch_i, id_branch_taken_i,
           ex_rd_i, ex_reg_write_i, ex_mem_read_i, mem_rd_i, mem_mem_read_i,
           dmem_req_i, dmem_ready_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
           err_timeout_o, stall_cnt_o, flush_cnt_o, wait_cnt_o
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use and branch-operand hazard detection for the instruction in ID.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [RV_REG_W-1:0] id_rs1,
  input  logic [RV_REG_W-1:0] id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic                id_branch,
  input  logic [RV_REG_W-1:0] ex_rd,
  input  logic                ex_reg_write,
  input  logic                ex_mem_read,
  input  logic [RV_REG_W-1:0] mem_rd,
  input  logic                mem_mem_read,
  output logic                hz_lu_c,
  output logic                hz_br_c
);

  logic ex_dep;
  logic mem_dep;

  // x0 is hardwired to zero, so a write to it never creates a dependency
  function automatic logic reads_reg(input logic [RV_REG_W-1:0] r,
                                     input logic [RV_REG_W-1:0] rs1,
                                     input logic [RV_REG_W-1:0] rs2,
                                     input logic use1,
                                     input logic use2);
    return (r != REG_X0) && ((use1 && (rs1 == r)) || (use2 && (rs2 == r)));
  endfunction

  always_comb begin
    ex_dep  = reads_reg(ex_rd,  id_rs1, id_rs2, id_use_rs1, id_use_rs2);
    mem_dep = reads_reg(mem_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);
    hz_lu_c = ex_mem_read && ex_dep;
    hz_br_c = id_branch && ((ex_reg_write && ex_dep) || (mem_mem_read && mem_dep));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/hold sequencer for the 5-stage RV32I pipeline with a dcache-miss freeze FSM.
// Optional perf counters are built when PIPELINE_CTRL_PERF_CNT_EN is defined.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pipeline_ctrl_if.slave bus
);

  localparam int unsigned WCNT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(WAIT_TIMEOUT);

  state_e            state;
  state_e            state_nxt;
  logic [WCNT_W-1:0] wait_q;
  logic [WCNT_W-1:0] wait_inc;
  logic              err_q;
  logic              hz_lu_c;
  logic              hz_br_c;
  logic              stall_c;
  logic              take_c;
  logic              hold_c;
  ctrl_t             ctrl_c;

  hazard_detect u_hazard_detect (
    .id_rs1       (bus.id_rs1_i),
    .id_rs2       (bus.id_rs2_i),
    .id_use_rs1   (bus.id_use_rs1_i),
    .id_use_rs2   (bus.id_use_rs2_i),
    .id_branch    (bus.id_branch_i),
    .ex_rd        (bus.ex_rd_i),
    .ex_reg_write (bus.ex_reg_write_i),
    .ex_mem_read  (bus.ex_mem_read_i),
    .mem_rd       (bus.mem_rd_i),
    .mem_mem_read (bus.mem_mem_read_i),
    .hz_lu_c      (hz_lu_c),
    .hz_br_c      (hz_br_c)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (bus.dmem_req_i && !bus.dmem_ready_i) state_nxt = MEM_WAIT;
      MEM_WAIT: if (bus.dmem_ready_i) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // Wait counter saturates at the timeout so a long miss cannot wrap it
  assign wait_inc = (wait_q == WAIT_MAX) ? wait_q : wait_q + WCNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else if (state == RUN) begin
      if (state_nxt == MEM_WAIT) wait_q <= '0;
    end else if (!bus.dmem_ready_i) begin
      wait_q <= wait_inc;
      if (wait_inc == WAIT_MAX) err_q <= 1'b1;
    end
  end

  // The ready cycle is not held so the pipeline advances on that edge
  always_comb begin
    stall_c = hz_lu_c || hz_br_c;
    take_c  = bus.id_branch_i && bus.id_branch_taken_i && !stall_c;
    hold_c  = !rst_i && bus.dmem_req_i && !bus.dmem_ready_i && (state == RUN);
    if (!rst_i && (state == MEM_WAIT) && !bus.dmem_ready_i) hold_c = 1'b1;
  end

  always_comb begin
    ctrl_c = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
               idex_bubble: 1'b0, pipe_hold: 1'b0};
    if (rst_i) begin
      ctrl_c = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                 idex_bubble: 1'b1, pipe_hold: 1'b0};
    end else if (hold_c) begin
      ctrl_c.pc_write   = 1'b0;
      ctrl_c.ifid_write = 1'b0;
      ctrl_c.pipe_hold  = 1'b1;
    end else if (stall_c) begin
      ctrl_c.pc_write    = 1'b0;
      ctrl_c.ifid_write  = 1'b0;
      ctrl_c.idex_bubble = 1'b1;
    end else if (take_c) begin
      ctrl_c.ifid_flush = 1'b1;
    end
  end

  assign bus.pc_write_o    = ctrl_c.pc_write;
  assign bus.ifid_write_o  = ctrl_c.ifid_write;
  assign bus.ifid_flush_o  = ctrl_c.ifid_flush;
  assign bus.idex_bubble_o = ctrl_c.idex_bubble;
  assign bus.pipe_hold_o   = ctrl_c.pipe_hold;
  assign bus.err_timeout_o = err_q;

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] wait_cnt_q;

  // Saturating perf counters; the reset branch keeps the reset cycle uncounted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (stall_c && !hold_c && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (ctrl_c.ifid_flush && (flush_cnt_q != CNT_MAX))  flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (hold_c && (wait_cnt_q != CNT_MAX))              wait_cnt_q  <= wait_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
  assign bus.wait_cnt_o  = wait_cnt_q;
`else
  assign bus.stall_cnt_o = {CNT_W{1'b0}};
  assign bus.flush_cnt_o = {CNT_W{1'b0}};
  assign bus.wait_cnt_o  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: per-cycle expected enables queued on drive, popped on sample.
module tb_pipeline_ctrl;

  localparam logic [4:0] NORM  = 5'b11000;  // {pc_write, ifid_write, flush, bubble, hold}
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] FLUSH = 5'b11100;
  localparam logic [4:0] HOLD  = 5'b00001;
  localparam logic [4:0] RST   = 5'b00110;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       br;
    logic       tk;
    logic [4:0] ex_rd;
    logic       ex_rw;
    logic       ex_mr;
    logic [4:0] mem_rd;
    logic       mem_mr;
    logic       req;
    logic       rdy;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;
  int   exp_wait  = 0;
  logic [4:0] exp_q[$];

  pipeline_ctrl_if #(.CNT_W(32)) bus ();

  pipeline_ctrl #(.WAIT_TIMEOUT(4), .CNT_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected enables, sample mid-cycle
  task automatic step(input stim_t s, input logic [4:0] exp, input string tag);
    logic [4:0] e;
    @(negedge clk);
    rst                   = s.rst;
    bus.id_rs1_i          = s.rs1;
    bus.id_rs2_i          = s.rs2;
    bus.id_use_rs1_i      = s.use1;
    bus.id_use_rs2_i      = s.use2;
    bus.id_branch_i       = s.br;
    bus.id_branch_taken_i = s.tk;
    bus.ex_rd_i           = s.ex_rd;
    bus.ex_reg_write_i    = s.ex_rw;
    bus.ex_mem_read_i     = s.ex_mr;
    bus.mem_rd_i          = s.mem_rd;
    bus.mem_mem_read_i    = s.mem_mr;
    bus.dmem_req_i        = s.req;
    bus.dmem_ready_i      = s.rdy;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    check(tag, 32'({bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o,
                    bus.idex_bubble_o, bus.pipe_hold_o}), 32'(e));
    check({tag, "_stall_cnt"}, bus.stall_cnt_o, 32'(exp_stall));
    check({tag, "_flush_cnt"}, bus.flush_cnt_o, 32'(exp_flush));
    check({tag, "_wait_cnt"},  bus.wait_cnt_o,  32'(exp_wait));
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    if (e == RST) begin
      exp_stall = 0; exp_flush = 0; exp_wait = 0;
    end else begin
      if (e == STALL) exp_stall++;
      if (e == FLUSH) exp_flush++;
      if (e == HOLD)  exp_wait++;
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    s = '0;
    s.rst = 1'b1;
    step(s, RST, "reset0");
    step(s, RST, "reset1");
    s = '0;
    step(s, NORM, "idle");
    check("err_after_reset", 32'(bus.err_timeout_o), 32'd0);

    // Load-use on rs1, then the load moves on
    s = '0; s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 5; s.use1 = 1; s.rs1 = 5;
    step(s, STALL, "lu_rs1");
    s = '0; s.mem_mr = 1; s.mem_rd = 5; s.use1 = 1; s.rs1 = 5;
    step(s, NORM, "lu_release");
    s = '0; s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 9; s.use2 = 1; s.rs2 = 9;
    step(s, STALL, "lu_rs2");
    s = '0; s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 5; s.use1 = 0; s.rs1 = 5;
    step(s, NORM, "lu_unused_reg");
    s = '0; s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 0; s.use1 = 1; s.use2 = 1;
    step(s, NORM, "x0_filter");
    s = '0; s.ex_rw = 1; s.ex_rd = 7; s.use1 = 1; s.rs1 = 7;
    step(s, NORM, "alu_dep_nonbranch");

    // beq x6,x0 after lw x6: EX hit, MEM hit, then taken
    s = '0; s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 6;
    s.br = 1; s.tk = 1; s.use1 = 1; s.use2 = 1; s.rs1 = 6; s.rs2 = 0;
    step(s, STALL, "br_lw_ex");
    s.ex_mr = 0; s.ex_rw = 0; s.ex_rd = 0; s.mem_mr = 1; s.mem_rd = 6;
    step(s, STALL, "br_lw_mem");
    s.mem_mr = 0; s.mem_rd = 0;
    step(s, FLUSH, "br_lw_taken");
    s = '0;
    step(s, NORM, "br_lw_after");

    // Branch after ALU op: a single stall
    s = '0; s.ex_rw = 1; s.ex_rd = 7; s.br = 1; s.tk = 1; s.use1 = 1; s.rs1 = 7;
    step(s, STALL, "br_alu_ex");
    s.ex_rw = 0; s.ex_rd = 0; s.mem_rd = 7;
    step(s, FLUSH, "br_alu_taken");
    s = '0; s.ex_rw = 1; s.ex_rd = 8; s.br = 1; s.tk = 0; s.use2 = 1; s.rs2 = 8;
    step(s, STALL, "br_nt_ex");
    s.ex_rw = 0; s.ex_rd = 0; s.mem_rd = 8;
    step(s, NORM, "br_nt_resolve");
    s = '0; s.ex_rd = 3; s.br = 1; s.tk = 1; s.use1 = 1; s.rs1 = 3;
    step(s, FLUSH, "br_ex_no_write");

    // Miss: five held cycles with a hazard underneath, released on ready
    s = '0; s.req = 1; s.rdy = 0;
    step(s, HOLD, "miss_1");
    step(s, HOLD, "miss_2");
    s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 5; s.use1 = 1; s.rs1 = 5;
    step(s, HOLD, "miss_3_over_stall");
    s = '0; s.req = 1; s.rdy = 0;
    step(s, HOLD, "miss_4");
    step(s, HOLD, "miss_5");
    s.rdy = 1;
    step(s, NORM, "miss_release");
    s = '0;
    step(s, NORM, "miss_back_in_run");
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    check("wait_cnt_miss", bus.wait_cnt_o, 32'd5);
`else
    check("wait_cnt_miss", bus.wait_cnt_o, 32'd0);
`endif

    s = '0; s.rst = 1;
    step(s, RST, "reset_pulse");
    s = '0;
    step(s, NORM, "post_reset");
    check("err_cleared", 32'(bus.err_timeout_o), 32'd0);

    // Timeout with WAIT_TIMEOUT=4: ready low for 10 cycles
    s = '0; s.req = 1; s.rdy = 0;
    for (int i = 0; i < 10; i++) begin
      step(s, HOLD, "timeout_wait");
      if (i == 1) check("err_early", 32'(bus.err_timeout_o), 32'd0);
      if (i == 9) check("err_set",   32'(bus.err_timeout_o), 32'd1);
    end
    s.rdy = 1;
    step(s, NORM, "timeout_release");
    s = '0;
    step(s, NORM, "timeout_run");
    check("err_sticky", 32'(bus.err_timeout_o), 32'd1);

    // Reset in the middle of a miss
    s = '0; s.req = 1; s.rdy = 0;
    step(s, HOLD, "rw_1");
    step(s, HOLD, "rw_2");
    s.rst = 1;
    step(s, RST, "rw_reset");
    s = '0;
    step(s, NORM, "rw_run");
    check("rw_err", 32'(bus.err_timeout_o), 32'd0);
    check("rw_wait_cnt", bus.wait_cnt_o, 32'd0);
    check("rw_flush_cnt", bus.flush_cnt_o, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
